regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//  Front-end controller for the 32x32 register file: arbitrates two writeback sources (A: ALU,
//  B: load unit) onto the single write port and sequences reads around the file's one-cycle
//  registered read. Reads see writes granted in the same cycle via an internal bypass; R0 is
//  hard-wired to zero. Sits between the CPU writeback/decode stages and register_file.
// PARAMETERS
//  DATA_W     32  register data width
//  ADDR_W     5   architectural register index width
//  RF_ADDR_W  32  address width of the register-file ports (zero-extended from ADDR_W)
//  CNT_W      16  width of the saturating conflict counter
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          synchronous, active-high reset
//  wa_valid     in   1          source A write request
//  wa_addr      in   ADDR_W     source A destination register
//  wa_data      in   DATA_W     source A write data
//  wa_ready     out  1          source A granted this cycle (combinational)
//  wb_valid/wb_addr/wb_data/wb_ready   same as A, for source B
//  rd_req       in   1          read request, both operands
//  rd_addr_a    in   ADDR_W     operand A register index
//  rd_addr_b    in   ADDR_W     operand B register index
//  rd_valid     out  1          read data valid (1 cycle after rd_req)
//  rd_data_a    out  DATA_W     operand A value
//  rd_data_b    out  DATA_W     operand B value
//  rf_wren      out  1          -> register_file WrEn
//  rf_aw        out  RF_ADDR_W  -> register_file Aw
//  rf_dw        out  DATA_W     -> register_file Dw
//  rf_aa, rf_ab out  RF_ADDR_W  -> register_file Aa / Ab (zero-extended rd_addr_a/b)
//  rf_da, rf_db in   DATA_W     <- register_file Da / Db
//  conflict_cnt out  CNT_W      cycles with wa_valid & wb_valid both high, saturating
// BEHAVIOUR
//  Reset (clk edge with reset=1): rr_pri<=A, rd_valid<=0, rd_data_a/b<=0, bypass regs<=0,
//   conflict_cnt<=0. While reset=1: wa_ready=wb_ready=rf_wren=0; requests ignored.
//  Write arbitration, one grant per cycle, valid/ready: transfer when valid&ready.
//   - only one valid: grant it; rr_pri <= the other source.
//   - both valid: grant rr_pri source; rr_pri <= the other; loser holds valid/addr/data stable.
//   - none valid: no grant, rr_pri unchanged.
//   - ready never asserted without valid.
//  Write issue: on grant, rf_aw/rf_dw = granted addr/data (same cycle, combinational);
//   rf_wren = grant & (addr != 0). Writes to R0 are accepted (ready=1) and discarded.
//  Read: rf_aa/rf_ab = zero-extended rd_addr_a/b in the request cycle N. Edge N registers:
//   rd_valid<=rd_req; hit_x<=rd_req & rf_wren & (rf_aw==rd_addr_x); byp_x<=rf_dw.
//   Cycle N+1: rd_data_x = (addr_x==0) ? 0 : hit_x ? byp_x : rf_da/rf_db.
//   rd_data_a/b are registered; rf_da/rf_db merge through the N+1 mux only (no extra latency).
//   Back-to-back reads every cycle, no stalls; rd_data holds last value when rd_valid=0.
//  Latency: write visible to a read requested in the same cycle (bypass) or any later cycle.
//  conflict_cnt: +1 per cycle with both valid (not in reset); holds at 2^CNT_W-1.
//  Reset mid-operation: in-flight read dropped (rd_valid=0 next cycle); ungranted writes lost.
// STRUCTURE
//  Package regfile_pkg: REG_ZERO (ADDR_W'd0), SRC_A=1'b0 / SRC_B=1'b1 priority encoding,
//   DATA_W/ADDR_W defaults shared with register_file users.
//  Sub-module rr_arbiter2: 2-requester round-robin (req[1:0] -> gnt[1:0], owns rr_pri).
//  Top: address/data mux, R0 filter, read-bypass pipeline, conflict counter.
// TESTING
//  1 reset, then wa_valid addr=3 data=0xDEADBEEF -> wa_ready=1, rf_wren=1, rf_aw=3; read r3 next cycle -> 0xDEADBEEF.
//  2 wa,wb both valid 4 cycles (A->r1,B->r2 held) -> grants A,B,A,B; conflict_cnt=4 (CNT_W=16).
//  3 write r5=0x1234 and rd_req r5/r5 same cycle -> next cycle rd_valid=1, rd_data_a=rd_data_b=0x1234.
//  4 write r0=0xFFFFFFFF -> wa_ready=1, rf_wren=0; read r0 -> rd_data_a=0.
//  5 rd_req in cycle N, reset=1 at edge N -> rd_valid=0, rd_data_a/b=0 in N+1.
//  6 CNT_W=2, both valid 5 cycles -> conflict_cnt saturates at 3.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants: default widths, the zero register and
// the round-robin priority encoding used by the write arbiter.
package regfile_pkg;

    localparam int unsigned RF_DATA_W      = 32;
    localparam int unsigned RF_REG_ADDR_W  = 5;
    localparam int unsigned RF_PORT_ADDR_W = 32;
    localparam int unsigned RF_CNT_W       = 16;

    localparam logic [RF_REG_ADDR_W-1:0] REG_ZERO = '0;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is source A, index 1 is source B.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_pri;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_pri == SRC_A) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Priority passes to whichever source did not just win.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_pri <= SRC_A;
        end else if (gnt[0]) begin
            rr_pri <= SRC_B;
        end else if (gnt[1]) begin
            rr_pri <= SRC_A;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file front end: arbitrates two writeback sources onto the write port
// and returns read operands one cycle later with same-cycle write bypass.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = RF_DATA_W,
    parameter int unsigned ADDR_W    = RF_REG_ADDR_W,
    parameter int unsigned RF_ADDR_W = RF_PORT_ADDR_W,
    parameter int unsigned CNT_W     = RF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wa_valid,
    input  logic [ADDR_W-1:0]    wa_addr,
    input  logic [DATA_W-1:0]    wa_data,
    output logic                 wa_ready,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 wb_ready,
    input  logic                 rd_req,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    output logic                 rd_valid,
    output logic [DATA_W-1:0]    rd_data_a,
    output logic [DATA_W-1:0]    rd_data_b,
    output logic                 rf_wren,
    output logic [RF_ADDR_W-1:0] rf_aw,
    output logic [DATA_W-1:0]    rf_dw,
    output logic [RF_ADDR_W-1:0] rf_aa,
    output logic [RF_ADDR_W-1:0] rf_ab,
    input  logic [DATA_W-1:0]    rf_da,
    input  logic [DATA_W-1:0]    rf_db,
    output logic [CNT_W-1:0]     conflict_cnt
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              hit_a;
    logic              hit_b;
    logic              zero_a;
    logic              zero_b;
    logic [DATA_W-1:0] byp_data;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;
    logic [DATA_W-1:0] mux_a;
    logic [DATA_W-1:0] mux_b;

    assign req = reset ? 2'b00 : {wb_valid, wa_valid};

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign wa_ready = gnt[0];
    assign wb_ready = gnt[1];

    // Granted write goes straight to the port; R0 writes are accepted but never issued.
    always_comb begin
        wr_addr = wa_addr;
        wr_data = wa_data;
        if (gnt[1]) begin
            wr_addr = wb_addr;
            wr_data = wb_data;
        end
        wr_en = (|gnt) && (wr_addr != ADDR_W'(REG_ZERO));
    end

    assign rf_wren = wr_en;
    assign rf_aw   = RF_ADDR_W'(wr_addr);
    assign rf_dw   = wr_data;
    assign rf_aa   = RF_ADDR_W'(rd_addr_a);
    assign rf_ab   = RF_ADDR_W'(rd_addr_b);

    // Read pipeline: record zero/bypass decisions now, merge with file data next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            hit_a    <= 1'b0;
            hit_b    <= 1'b0;
            zero_a   <= 1'b0;
            zero_b   <= 1'b0;
            byp_data <= '0;
            hold_a   <= '0;
            hold_b   <= '0;
        end else begin
            rd_valid <= rd_req;
            hit_a    <= rd_req && wr_en && (wr_addr == rd_addr_a);
            hit_b    <= rd_req && wr_en && (wr_addr == rd_addr_b);
            zero_a   <= (rd_addr_a == ADDR_W'(REG_ZERO));
            zero_b   <= (rd_addr_b == ADDR_W'(REG_ZERO));
            byp_data <= wr_data;
            if (rd_valid) begin
                hold_a <= mux_a;
                hold_b <= mux_b;
            end
        end
    end

    always_comb begin
        mux_a = zero_a ? '0 : (hit_a ? byp_data : rf_da);
        mux_b = zero_b ? '0 : (hit_b ? byp_data : rf_db);
    end

    // Outside a valid cycle the last delivered operands are held.
    assign rd_data_a = rd_valid ? mux_a : hold_a;
    assign rd_data_b = rd_valid ? mux_b : hold_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (wa_valid && wb_valid && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed scenarios plus randomized traffic checked
// against an architectural register model; a second instance uses a 2-bit counter.
module tb_regfile_access_ctrl;

    logic        clk;
    logic        reset;
    logic        wa_valid, wb_valid, rd_req;
    logic [4:0]  wa_addr, wb_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wa_data, wb_data;

    logic        wa_ready, wb_ready, rd_valid, rf_wren;
    logic [31:0] rd_data_a, rd_data_b, rf_aw, rf_dw, rf_aa, rf_ab, rf_da, rf_db;
    logic [15:0] conflict_cnt;

    logic        s_wa_ready, s_wb_ready, s_rd_valid, s_rf_wren;
    logic [31:0] s_rd_data_a, s_rd_data_b, s_rf_aw, s_rf_dw, s_rf_aa, s_rf_ab, s_rf_da, s_rf_db;
    logic [1:0]  s_conflict_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_next_b;
    int          m_cnt, m_cnt2;
    logic        e_rd_valid;
    logic [31:0] e_rd_a, e_rd_b;
    logic        last_ga, last_gb;

    // Register-file stand-ins: registered read, write at the edge
    logic [31:0] mem1 [32];
    logic [31:0] mem2 [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_access_ctrl dut (
        .clk(clk), .reset(reset),
        .wa_valid(wa_valid), .wa_addr(wa_addr), .wa_data(wa_data), .wa_ready(wa_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rf_wren(rf_wren), .rf_aw(rf_aw), .rf_dw(rf_dw), .rf_aa(rf_aa), .rf_ab(rf_ab),
        .rf_da(rf_da), .rf_db(rf_db), .conflict_cnt(conflict_cnt)
    );

    regfile_access_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .wa_valid(wa_valid), .wa_addr(wa_addr), .wa_data(wa_data), .wa_ready(s_wa_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(s_wb_ready),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_valid(s_rd_valid), .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
        .rf_wren(s_rf_wren), .rf_aw(s_rf_aw), .rf_dw(s_rf_dw), .rf_aa(s_rf_aa), .rf_ab(s_rf_ab),
        .rf_da(s_rf_da), .rf_db(s_rf_db), .conflict_cnt(s_conflict_cnt)
    );

    always @(posedge clk) begin
        if (rf_wren) mem1[rf_aw[4:0]] <= rf_dw;
        rf_da <= mem1[rf_aa[4:0]];
        rf_db <= mem1[rf_ab[4:0]];
        if (s_rf_wren) mem2[s_rf_aw[4:0]] <= s_rf_dw;
        s_rf_da <= mem2[s_rf_aa[4:0]];
        s_rf_db <= mem2[s_rf_ab[4:0]];
    end

    function automatic logic grant_a();
        return !reset && wa_valid && (!wb_valid || !m_next_b);
    endfunction

    function automatic logic grant_b();
        return !reset && wb_valid && (!wa_valid || m_next_b);
    endfunction

    // Advance the model by one clock with the inputs currently applied, then step the clock.
    task automatic tick();
        logic ga, gb;
        ga = grant_a();
        gb = grant_b();
        last_ga = ga;
        last_gb = gb;
        if (reset) begin
            m_next_b   = 1'b0;
            m_cnt      = 0;
            m_cnt2     = 0;
            e_rd_valid = 1'b0;
            e_rd_a     = 32'd0;
            e_rd_b     = 32'd0;
        end else begin
            if (ga && wa_addr != 5'd0) m_regs[wa_addr] = wa_data;
            if (gb && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
            if (ga) m_next_b = 1'b1;
            else if (gb) m_next_b = 1'b0;
            if (wa_valid && wb_valid) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
                m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            end
            e_rd_valid = rd_req;
            if (rd_req) begin
                e_rd_a = (rd_addr_a == 5'd0) ? 32'd0 : m_regs[rd_addr_a];
                e_rd_b = (rd_addr_b == 5'd0) ? 32'd0 : m_regs[rd_addr_b];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wa_valid = 0; wb_valid = 0; rd_req = 0;
        wa_addr = 0; wb_addr = 0; rd_addr_a = 0; rd_addr_b = 0;
        wa_data = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        wa_valid = 1; wa_addr = 5'd7; wa_data = 32'h1111_2222;
        wb_valid = 1; wb_addr = 5'd8; rd_req = 1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({wa_ready, wb_ready, rf_wren} !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b required 000", {wa_ready, wb_ready, rf_wren});
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            errors++; $display("FAIL reset_read: got v=%b a=%h b=%h required 0", rd_valid, rd_data_a, rd_data_b);
        end
        checks++;
        if (conflict_cnt !== 16'd0 || s_conflict_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d required 0", conflict_cnt, s_conflict_cnt);
        end
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        idle_inputs();
        wa_valid = 1; wa_addr = 5'd3; wa_data = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (wa_ready !== 1'b1 || rf_wren !== 1'b1 || rf_aw !== 32'd3 || rf_dw !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_issue: got rdy=%b wren=%b aw=%h dw=%h required 1 1 3 deadbeef",
                               wa_ready, rf_wren, rf_aw, rf_dw);
        end
        tick();
        idle_inputs();
        rd_req = 1; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
        @(negedge clk);
        checks++;
        if (rf_aa !== 32'd3 || rf_ab !== 32'd3) begin
            errors++; $display("FAIL read_addr: got %h/%h required 3", rf_aa, rf_ab);
        end
        tick();
        rd_req = 0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data_a !== 32'hDEAD_BEEF || rd_data_b !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_read: got v=%b a=%h b=%h required 1 deadbeef", rd_valid, rd_data_a, rd_data_b);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data_a !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_hold: got v=%b a=%h required 0 deadbeef", rd_valid, rd_data_a);
        end
    endtask

    task automatic test_conflict();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        idle_inputs();
        do_reset();
        wa_valid = 1; wa_addr = 5'd1; wa_data = 32'hA1A1_0001;
        wb_valid = 1; wb_addr = 5'd2; wb_data = 32'hB2B2_0002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({wb_ready, wa_ready} !== exp_g[i]) begin
                errors++; $display("FAIL conflict_grant[%0d]: got %b required %b", i, {wb_ready, wa_ready}, exp_g[i]);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'd4) begin
            errors++; $display("FAIL conflict_cnt: got %0d required 4", conflict_cnt);
        end
        tick();
    endtask

    task automatic test_bypass();
        idle_inputs();
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        rd_req = 1; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        @(negedge clk);
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data_a !== 32'h1234 || rd_data_b !== 32'h1234) begin
            errors++; $display("FAIL bypass: got v=%b a=%h b=%h required 1 1234", rd_valid, rd_data_a, rd_data_b);
        end
        tick();
    endtask

    task automatic test_r0();
        idle_inputs();
        wa_valid = 1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
        rd_req = 1; rd_addr_a = 5'd0; rd_addr_b = 5'd5;
        @(negedge clk);
        checks++;
        if (wa_ready !== 1'b1 || rf_wren !== 1'b0) begin
            errors++; $display("FAIL r0_write: got rdy=%b wren=%b required 1 0", wa_ready, rf_wren);
        end
        tick();
        idle_inputs();
        rd_req = 1; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        @(negedge clk);
        checks++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'h1234) begin
            errors++; $display("FAIL r0_bypass_read: got a=%h b=%h required 0 1234", rd_data_a, rd_data_b);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            errors++; $display("FAIL r0_read: got a=%h b=%h required 0", rd_data_a, rd_data_b);
        end
        tick();
    endtask

    task automatic test_reset_midread();
        idle_inputs();
        rd_req = 1; rd_addr_a = 5'd3; rd_addr_b = 5'd5;
        wa_valid = 1; wa_addr = 5'd9; wa_data = 32'h9999_9999;
        reset = 1'b1;
        @(negedge clk);
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            errors++; $display("FAIL reset_midread: got v=%b a=%h b=%h required 0", rd_valid, rd_data_a, rd_data_b);
        end
        tick();
    endtask

    task automatic test_saturation();
        idle_inputs();
        do_reset();
        wa_valid = 1; wa_addr = 5'd10; wa_data = 32'h0A0A_0A0A;
        wb_valid = 1; wb_addr = 5'd11; wb_data = 32'h0B0B_0B0B;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (s_conflict_cnt !== 2'd3 || conflict_cnt !== 16'd5) begin
            errors++; $display("FAIL saturation: got %0d/%0d required 3/5", s_conflict_cnt, conflict_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            if (!(wa_valid && !last_ga)) begin
                wa_valid = ($urandom_range(0, 99) < 60);
                wa_addr  = 5'($urandom_range(0, 7));
                wa_data  = $urandom;
            end
            if (!(wb_valid && !last_gb)) begin
                wb_valid = ($urandom_range(0, 99) < 60);
                wb_addr  = 5'($urandom_range(0, 7));
                wb_data  = $urandom;
            end
            rd_req    = ($urandom_range(0, 99) < 70);
            rd_addr_a = 5'($urandom_range(0, 7));
            rd_addr_b = 5'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 99) < 2);
            @(negedge clk);
            checks++;
            if (wa_ready !== grant_a() || wb_ready !== grant_b() ||
                s_wa_ready !== grant_a() || s_wb_ready !== grant_b()) begin
                errors++; $display("FAIL rand_grant[%0d]: got %b%b/%b%b required %b%b", c, wa_ready, wb_ready,
                                   s_wa_ready, s_wb_ready, grant_a(), grant_b());
            end
            checks++;
            if (rd_valid !== e_rd_valid || rd_data_a !== e_rd_a || rd_data_b !== e_rd_b) begin
                errors++; $display("FAIL rand_read[%0d]: got v=%b a=%h b=%h required v=%b a=%h b=%h",
                                   c, rd_valid, rd_data_a, rd_data_b, e_rd_valid, e_rd_a, e_rd_b);
            end
            checks++;
            if (s_rd_valid !== e_rd_valid || s_rd_data_a !== e_rd_a || s_rd_data_b !== e_rd_b) begin
                errors++; $display("FAIL rand_read_sat[%0d]: got v=%b a=%h b=%h required v=%b a=%h b=%h",
                                   c, s_rd_valid, s_rd_data_a, s_rd_data_b, e_rd_valid, e_rd_a, e_rd_b);
            end
            checks++;
            if (conflict_cnt !== 16'(m_cnt) || s_conflict_cnt !== 2'(m_cnt2)) begin
                errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d required %0d/%0d",
                                   c, conflict_cnt, s_conflict_cnt, m_cnt, m_cnt2);
            end
            checks++;
            if (rf_aa !== 32'(rd_addr_a) || rf_ab !== 32'(rd_addr_b) ||
                s_rf_aa !== 32'(rd_addr_a) || s_rf_ab !== 32'(rd_addr_b)) begin
                errors++; $display("FAIL rand_raddr[%0d]: got %h %h required %h %h", c, rf_aa, rf_ab, rd_addr_a, rd_addr_b);
            end
            if (grant_a() || grant_b()) begin
                checks++;
                if (rf_wren !== ((grant_a() ? wa_addr : wb_addr) != 5'd0) ||
                    rf_aw !== 32'(grant_a() ? wa_addr : wb_addr) ||
                    rf_dw !== (grant_a() ? wa_data : wb_data) ||
                    s_rf_wren !== rf_wren || s_rf_aw !== rf_aw || s_rf_dw !== rf_dw) begin
                    errors++; $display("FAIL rand_wport[%0d]: got wren=%b aw=%h dw=%h", c, rf_wren, rf_aw, rf_dw);
                end
            end else begin
                checks++;
                if (rf_wren !== 1'b0 || s_rf_wren !== 1'b0) begin
                    errors++; $display("FAIL rand_nowrite[%0d]: got wren=%b/%b required 0", c, rf_wren, s_rf_wren);
                end
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            mem1[i]   = 32'd0;
            mem2[i]   = 32'd0;
        end
        m_next_b = 1'b0; m_cnt = 0; m_cnt2 = 0;
        e_rd_valid = 1'b0; e_rd_a = 32'd0; e_rd_b = 32'd0;
        last_ga = 1'b0; last_gb = 1'b0;
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_write_read();
        test_conflict();
        test_bypass();
        test_r0();
        test_reset_midread();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
